// File: rtl/prng_pkg.sv
// Shared types and helpers for the LFSR word bank: FSM states, default feedback
// mask and the single-step Galois LFSR function.
package prng_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    READY,
    DRAIN
  } state_t;

  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  // Callers zero-extend narrower words into this width; WIDTH must not exceed it.
  localparam int STEP_W = 64;

  function automatic logic [STEP_W-1:0] lfsr_step(input logic [STEP_W-1:0] s,
                                                  input logic [STEP_W-1:0] taps);
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

endpackage

// File: rtl/prng_dpram.sv
// Inferred dual-port RAM with two write ports and a registered 1-cycle read on
// port A; contents are never reset.
module prng_dpram #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_we_a,
  input  logic [AW-1:0]    i_addr_a,
  input  logic [WIDTH-1:0] i_wdata_a,
  output logic [WIDTH-1:0] o_rdata_a,
  input  logic             i_we_b,
  input  logic [AW-1:0]    i_addr_b,
  input  logic [WIDTH-1:0] i_wdata_b
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata_a;

  // The two ports never target the same address in one cycle, so write order is moot.
  always_ff @(posedge i_clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    r_rdata_a <= r_mem[i_addr_a];
  end

  assign o_rdata_a = r_rdata_a;

endmodule

// File: rtl/prng_lfsr_bank.sv
// Generates a block of Galois-LFSR words into an internal RAM, LANES words per
// cycle from a wrapping start address, then streams them out over valid/ready.
module prng_lfsr_bank
  import prng_pkg::*;
#(
  parameter  int               WIDTH = 32,
  parameter  int               DEPTH = 1024,
  parameter  int               LANES = 2,
  parameter  logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS),
  localparam int               AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [AW:0]      count,
  input  logic [AW-1:0]    start_addr,
  output logic             busy,
  output logic             done,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_last
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [AW-1:0]    r_waddr;
  logic [AW-1:0]    r_raddr;
  logic [AW:0]      r_remain;
  logic [AW:0]      r_issue_left;
  logic             r_nonzero;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] r_buf_data [2];
  logic [1:0]       r_buf_last;
  logic             r_head;
  logic [1:0]       r_cnt;
  logic             r_inflight;
  logic             r_inflight_last;

  logic [AW:0]      w_count_sat;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_word0;
  logic [WIDTH-1:0] w_word1;
  logic             w_start_ok;
  logic             w_two_lanes;
  logic [1:0]       w_lanes_now;
  logic             w_last_fill;
  logic             w_we_a;
  logic             w_we_b;
  logic [AW-1:0]    w_addr_a;
  logic [AW-1:0]    w_addr_b;
  logic [WIDTH-1:0] w_qa;
  logic [1:0]       w_occ;
  logic             w_pop;
  logic             w_issue;
  logic             w_issue_last;
  logic             w_wr_idx;

  assign w_count_sat = (count > DEPTH_W) ? DEPTH_W : count;
  assign w_seed      = (seed == '0) ? WIDTH'(1) : seed;
  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == READY));

  // Lane 1 continues the sequence from lane 0 so both words land in the same cycle.
  assign w_word0     = WIDTH'(lfsr_step(STEP_W'(r_lfsr), STEP_W'(TAPS)));
  assign w_word1     = WIDTH'(lfsr_step(STEP_W'(w_word0), STEP_W'(TAPS)));
  assign w_two_lanes = (LANES == 2) && (r_remain > (AW+1)'(1));
  assign w_lanes_now = w_two_lanes ? 2'd2 : 2'd1;
  assign w_last_fill = (r_remain == (AW+1)'(w_lanes_now));

  assign w_we_a   = (r_state == FILL);
  assign w_we_b   = w_we_a && w_two_lanes;
  assign w_addr_a = w_we_a ? r_waddr : r_raddr;
  assign w_addr_b = r_waddr + AW'(1);

  prng_dpram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk     (clk),
    .i_we_a    (w_we_a),
    .i_addr_a  (w_addr_a),
    .i_wdata_a (w_word0),
    .o_rdata_a (w_qa),
    .i_we_b    (w_we_b),
    .i_addr_b  (w_addr_b),
    .i_wdata_b (w_word1)
  );

  // A read may be issued only if the buffer is guaranteed a free slot when its data returns.
  assign w_pop        = rd_valid && rd_ready;
  assign w_occ        = r_cnt + {1'b0, r_inflight};
  assign w_issue      = ((r_state == READY) || (r_state == DRAIN)) && !w_start_ok &&
                        (r_issue_left != '0) && ((w_occ < 2'd2) || w_pop);
  assign w_issue_last = (r_issue_left == (AW+1)'(1));
  assign w_wr_idx     = r_head ^ r_cnt[0];

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state      <= IDLE;
      r_lfsr       <= '0;
      r_waddr      <= '0;
      r_raddr      <= '0;
      r_remain     <= '0;
      r_issue_left <= '0;
      r_nonzero    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else if (w_start_ok) begin
      r_lfsr       <= w_seed;
      r_waddr      <= start_addr;
      r_raddr      <= start_addr;
      r_remain     <= w_count_sat;
      r_issue_left <= w_count_sat;
      r_nonzero    <= (w_count_sat != '0);
      r_busy       <= (w_count_sat != '0);
      r_done       <= (w_count_sat == '0);
      r_state      <= (w_count_sat == '0) ? READY : FILL;
    end else begin
      if (w_issue) begin
        r_raddr      <= r_raddr + AW'(1);
        r_issue_left <= r_issue_left - (AW+1)'(1);
      end
      case (r_state)
        IDLE: r_state <= IDLE;
        FILL: begin
          r_lfsr   <= w_two_lanes ? w_word1 : w_word0;
          r_waddr  <= r_waddr + AW'(w_lanes_now);
          r_remain <= r_remain - (AW+1)'(w_lanes_now);
          if (w_last_fill) begin
            r_state <= READY;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        READY: r_state <= r_nonzero ? DRAIN : IDLE;
        DRAIN: if (w_pop && rd_last) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Two-entry output FIFO absorbing the RAM read latency; a restart drops anything pending.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2; i++) r_buf_data[i] <= '0;
      r_buf_last      <= '0;
      r_head          <= 1'b0;
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else if (w_start_ok) begin
      r_cnt           <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue_last;
      if (r_inflight) begin
        r_buf_data[w_wr_idx] <= w_qa;
        r_buf_last[w_wr_idx] <= r_inflight_last;
      end
      if (w_pop) r_head <= ~r_head;
      r_cnt <= r_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rd_valid = (r_cnt != '0);
  assign rd_data  = r_buf_data[r_head];
  assign rd_last  = rd_valid && r_buf_last[r_head];

endmodule
